// File: rtl/bcd_seg_display_mux_if.sv
// bcd_seg_display_mux_if
// Groups the digit data, control strobes and display drive signals of the
// time-multiplexed 7-segment display driver into one bundle.
//   enable      : 1 = scan running, 0 = display dark with the scan position held
//   load        : request to capture bcd_in at the next frame boundary
//   bcd_in      : packed BCD digits, digit k = bcd_in[4k+3:4k], digit 0 least significant
//   seg         : active-low segments, seg[0]=a ... seg[6]=g
//   an          : active-low one-hot digit select, an[k] lights digit k
//   digit_idx   : index of the digit currently driven
//   frame_done  : one-cycle pulse after the scan wraps back to digit 0
// Modports: master drives enable/load/bcd_in (the producer side),
//           slave is the display driver itself.
interface bcd_seg_display_mux_if #(
  parameter int NUM_DIGITS = 4
);
  logic                      enable;
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   bcd_in;
  logic [6:0]                seg;
  logic [NUM_DIGITS-1:0]     an;
  logic [2:0]                digit_idx;
  logic                      frame_done;

  modport master (
    output enable, load, bcd_in,
    input  seg, an, digit_idx, frame_done
  );

  modport slave (
    input  enable, load, bcd_in,
    output seg, an, digit_idx, frame_done
  );
endinterface

// File: rtl/bcd_seg_display_mux.sv
// bcd_seg_display_mux
// Drives one time-multiplexed 7-segment display from NUM_DIGITS packed BCD
// digits. A refresh prescaler keeps each digit lit for REFRESH_DIV clocks, then
// the scan moves on to the next digit. New digit data is captured into a
// shadow register only at the frame boundary, so a changing counter chain
// never produces a torn (half old, half new) display.
// Parameters:
//   NUM_DIGITS   digits scanned (2..8)
//   REFRESH_DIV  clocks each digit stays lit (>= 2)
// Ports:
//   clk    : system clock, rising edge
//   clear  : asynchronous active-low reset
//   bus    : bcd_seg_display_mux_if slave modport (enable, load, bcd_in in;
//            seg, an, digit_idx, frame_done out)
// Optional feature macro: LEADING_ZERO_BLANK_EN
//   When defined, a zero digit is blanked if it and every digit above it are
//   zero; digit 0 is never blanked and invalid digits never count as zero.
//   When undefined, every digit is always decoded.
module bcd_seg_display_mux #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000
) (
  input logic                    clk,
  input logic                    clear,
  bcd_seg_display_mux_if.slave   bus
);

  localparam int             PW      = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0]  PRE_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [2:0]     IDX_MAX = 3'(NUM_DIGITS - 1);
  localparam logic [6:0]     SEG_OFF = 7'h7F;

  logic [PW-1:0]           presc_q, presc_d;
  logic [2:0]              idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic                    pending_q, pending_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_done_q, frame_done_d;

  logic                    tick;
  logic                    wrap;
  logic [3:0]              curDigit;
`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0]   blankVec;
  logic                    allZero;
  logic                    blankSel;
`endif

  // Active-low decode in g..a order; anything outside 0..9 shows a dash.
  function automatic logic [6:0] decode7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  // Next-state logic. The display outputs are computed from the post-edge
  // scan index and post-edge shadow contents, so on the wrap edge digit 0
  // already shows freshly captured data.
  always_comb begin
    tick         = bus.enable && (presc_q == PRE_MAX);
    wrap         = tick && (idx_q == IDX_MAX);

    presc_d      = presc_q;
    idx_d        = idx_q;
    shadow_d     = shadow_q;
    pending_d    = pending_q | bus.load;
    frame_done_d = wrap;
    an_d         = '1;
    seg_d        = SEG_OFF;
    curDigit     = 4'd0;

    if (bus.enable) begin
      presc_d = (presc_q == PRE_MAX) ? '0 : presc_q + 1'b1;
    end

    if (tick) begin
      idx_d = wrap ? 3'd0 : idx_q + 3'd1;
    end

    // A load seen this cycle counts as pending, so a load on the wrap
    // cycle itself still captures on that edge.
    if (wrap) begin
      pending_d = 1'b0;
      if (pending_q || bus.load) begin
        shadow_d = bus.bcd_in;
      end
    end

    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_d == 3'(k)) begin
        curDigit = shadow_d[4*k +: 4];
      end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Walk down from the top digit; a digit is blankable while every digit
    // from it upward is exactly zero. Digit 0 always stays visible.
    blankVec = '0;
    allZero  = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      allZero     = allZero && (shadow_d[4*k +: 4] == 4'd0);
      blankVec[k] = allZero;
    end
    blankSel = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_d == 3'(k)) begin
        blankSel = blankVec[k];
      end
    end
`endif

    if (bus.enable) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        an_d[k] = (idx_d != 3'(k));
      end
`ifdef LEADING_ZERO_BLANK_EN
      seg_d = blankSel ? SEG_OFF : decode7(curDigit);
`else
      seg_d = decode7(curDigit);
`endif
    end
  end

  // State and output registers; reset also discards any pending load.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      presc_q      <= '0;
      idx_q        <= 3'd0;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      seg_q        <= SEG_OFF;
      an_q         <= '1;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.digit_idx  = idx_q;
  assign bus.frame_done = frame_done_q;

endmodule
